// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU datapath.
//   - Condition codes used by the branch resolver and the ALU flag logic
//   - Branch/PC unit FSM state encoding
//   - Default datapath widths
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;

  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_LT     = 3'b010;
  localparam logic [2:0] COND_LE     = 3'b011;
  localparam logic [2:0] COND_ALWAYS = 3'b100;
  localparam logic [2:0] COND_NE     = 3'b101;
  localparam logic [2:0] COND_GE     = 3'b110;
  localparam logic [2:0] COND_GT     = 3'b111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: checks a signed operand against zero
// under a 3-bit condition code.
// Ports:
//   cond  in  3       condition code (cpu_pkg COND_*)
//   test  in  DATA_W  two's-complement operand compared against zero
//   take  out 1       condition holds
module branch_cond_eval
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        cond,
  input  logic [DATA_W-1:0] test,
  output logic              take
);

  logic is_zero;
  logic is_neg;

  // Sign bit alone decides "negative" for a two's-complement operand.
  assign is_zero = (test == '0);
  assign is_neg  = test[DATA_W-1];

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_NEVER:  take = 1'b0;
      COND_EQ:     take = is_zero;
      COND_LT:     take = is_neg;
      COND_LE:     take = is_neg | is_zero;
      COND_ALWAYS: take = 1'b1;
      COND_NE:     take = ~is_zero;
      COND_GE:     take = ~is_neg;
      COND_GT:     take = ~is_neg & ~is_zero;
      default:     take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch resolver plus program counter. A taken branch loads the target,
// pulses taken, and opens a flush window during which new requests are
// back-pressured and the PC holds.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_RUN   | accepting branches; PC advances on pc_en
//   ST_FLUSH | flush window after a taken branch; br_ready low, PC holds
//
// Ports:
//   clk        in  1       clock, rising edge
//   rst        in  1       synchronous reset, active high
//   br_valid   in  1       branch request present
//   br_ready   out 1       request can be accepted this cycle (from state)
//   br_cond    in  3       condition code
//   br_test    in  DATA_W  signed operand compared against zero
//   br_target  in  ADDR_W  branch destination
//   pc_en      in  1       advance PC by one (fetch step)
//   pc_out     out ADDR_W  program counter (registered)
//   taken      out 1       one-cycle pulse on a taken branch
//   flush      out 1       high for FLUSH_CYCLES cycles after a taken branch
//   taken_cnt  out CNT_W   saturating count of taken branches
module branch_pc_unit
  import cpu_pkg::*;
#(
  parameter int                 DATA_W       = DATA_W_DEF,
  parameter int                 ADDR_W       = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter int                 FLUSH_CYCLES = 2,
  parameter int                 CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [DATA_W-1:0] br_test,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              pc_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic              taken,
  output logic              flush,
  output logic [CNT_W-1:0]  taken_cnt
);

  // Down-counter is loaded with FLUSH_CYCLES-1 and the window ends on the
  // edge where it reads zero, so flush stays high exactly FLUSH_CYCLES cycles.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] flush_cnt;
  logic       cond_true;
  logic       take_branch;

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond (
    .cond (br_cond),
    .test (br_test),
    .take (cond_true)
  );

  assign br_ready    = (state == ST_RUN);
  assign take_branch = br_valid & br_ready & cond_true;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      pc_out    <= RESET_PC;
      taken     <= 1'b0;
      flush     <= 1'b0;
      taken_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (take_branch) begin
            // Target wins over a simultaneous fetch step.
            pc_out    <= br_target;
            taken     <= 1'b1;
            flush     <= 1'b1;
            flush_cnt <= FLUSH_LOAD;
            state     <= ST_FLUSH;
            if (taken_cnt != '1) begin
              taken_cnt <= taken_cnt + CNT_W'(1);
            end
          end else begin
            taken <= 1'b0;
            if (pc_en) begin
              pc_out <= pc_out + ADDR_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          taken <= 1'b0;
          if (flush_cnt == '0) begin
            state <= ST_RUN;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_RUN;
          flush <= 1'b0;
          taken <= 1'b0;
        end
      endcase
    end
  end

endmodule
